// File: rtl/sum_block_accumulator.sv
// Accumulates fixed-size blocks of upstream sums and emits one registered
// result per block (total, maximum, beat count) over a valid/ready handshake.
module sum_block_accumulator #(
  parameter  int DATA_IN_WIDTH = 8,
  parameter  int BLOCK_LEN     = 4,
  localparam int IN_W          = DATA_IN_WIDTH + 1,
  localparam int SUM_W         = IN_W + $clog2(BLOCK_LEN),
  localparam int CNT_W         = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush_i,
  output logic [SUM_W-1:0] out_sum,
  output logic [IN_W-1:0]  out_max,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(BLOCK_LEN);

  function automatic logic [IN_W-1:0] max_u(input logic [IN_W-1:0] a,
                                            input logic [IN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t           state, state_nx;
  logic [SUM_W-1:0] acc_p0, acc_nx;
  logic [IN_W-1:0]  mx_p0, mx_nx;
  logic [CNT_W-1:0] cnt_p0, cnt_nx;
  logic [SUM_W-1:0] sum_p1;
  logic [IN_W-1:0]  max_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;
  logic             in_fire, out_fire, close;

  assign vld_p1    = (state == HOLD);
  assign in_ready  = (state == ACCUM) | out_ready;
  assign out_valid = vld_p1;
  assign out_sum   = sum_p1;
  assign out_max   = max_p1;
  assign out_cnt   = cnt_p1;

  // Accumulators are already cleared while a result is held, so a beat
  // accepted alongside out_fire naturally starts the next block from zero.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = vld_p1 & out_ready;
    acc_nx   = acc_p0;
    mx_nx    = mx_p0;
    if (in_fire) begin
      acc_nx = acc_p0 + SUM_W'(in_sum);
      mx_nx  = max_u(mx_p0, in_sum);
    end
    cnt_nx   = cnt_p0 + CNT_W'(in_fire);
    close    = (in_fire && (cnt_nx == LEN_C)) || (flush_i && (cnt_nx != '0));
    state_nx = state;
    if (close)
      state_nx = HOLD;
    else if ((state == HOLD) && out_fire)
      state_nx = ACCUM;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)
      state <= ACCUM;
    else
      state <= state_nx;
  end

  // Stage p0: running block accumulators
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc_p0 <= '0;
      mx_p0  <= '0;
      cnt_p0 <= '0;
    end else if (close) begin
      acc_p0 <= '0;
      mx_p0  <= '0;
      cnt_p0 <= '0;
    end else begin
      acc_p0 <= acc_nx;
      mx_p0  <= mx_nx;
      cnt_p0 <= cnt_nx;
    end
  end

  // Stage p1: registered block result, frozen until the next close
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sum_p1 <= '0;
      max_p1 <= '0;
      cnt_p1 <= '0;
    end else if (close) begin
      sum_p1 <= acc_nx;
      max_p1 <= mx_nx;
      cnt_p1 <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Self-checking bench for sum_block_accumulator: directed scenarios plus a
// randomized run, all checked against a queue-based block model.
module tb_sum_block_accumulator;
  localparam int DW    = 8;
  localparam int BL    = 4;
  localparam int IN_W  = DW + 1;
  localparam int SUM_W = IN_W + $clog2(BL);
  localparam int CNT_W = $clog2(BL + 1);

  logic             clk = 1'b0;
  logic             arst_i;
  logic [IN_W-1:0]  in_sum;
  logic             in_valid, in_ready, flush_i;
  logic [SUM_W-1:0] out_sum;
  logic [IN_W-1:0]  out_max;
  logic [CNT_W-1:0] out_cnt;
  logic             out_valid, out_ready;

  int checks = 0;
  int failures = 0;

  // Reference model: beats of the open block, and the one pending result
  logic [IN_W-1:0]  blk[$];
  logic             m_pending = 1'b0;
  logic             m_ready, obs_ready;
  logic [SUM_W-1:0] e_sum = '0;
  logic [IN_W-1:0]  e_max = '0;
  logic [CNT_W-1:0] e_cnt = '0;

  sum_block_accumulator #(.DATA_IN_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .clk_i(clk), .arst_i(arst_i), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(in_ready), .flush_i(flush_i), .out_sum(out_sum),
    .out_max(out_max), .out_cnt(out_cnt), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the model across the edge, return at edge+1.
  task automatic step(input logic v, input logic [IN_W-1:0] s,
                      input logic f, input logic ordy);
    logic fire, ofire;
    in_valid = v; in_sum = s; flush_i = f; out_ready = ordy;
    #1;
    obs_ready = in_ready;
    m_ready   = !m_pending || ordy;
    fire      = v && m_ready;
    ofire     = m_pending && ordy;
    if (ofire) m_pending = 1'b0;
    if (fire) blk.push_back(s);
    if (blk.size() == BL || (f && blk.size() > 0)) begin
      e_sum = '0;
      e_max = '0;
      foreach (blk[i]) begin
        e_sum += SUM_W'(blk[i]);
        if (blk[i] > e_max) e_max = blk[i];
      end
      e_cnt = CNT_W'(blk.size());
      m_pending = 1'b1;
      blk.delete();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush_i  = 1'b0;
  endtask

  task automatic test_reset();
    arst_i = 1'b1; in_valid = 1'b0; in_sum = '0; flush_i = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out_sum, out_max, out_cnt} !== '0) begin failures++;
      $display("FAIL reset_outputs got=%0d/%0d/%0d exp=0/0/0", out_sum, out_max, out_cnt); end
    @(negedge clk);
    arst_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int vals[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, IN_W'(vals[i]), 1'b0, 1'b1);
      checks++; if (out_valid !== (i == 3)) begin failures++;
        $display("FAIL basic_valid beat=%0d got=%b exp=%b", i, out_valid, (i == 3)); end
    end
    checks++; if (out_sum !== SUM_W'(100) || out_max !== IN_W'(40) || out_cnt !== CNT_W'(4)) begin failures++;
      $display("FAIL basic_result got=%0d/%0d/%0d exp=100/40/4", out_sum, out_max, out_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_width();
    for (int i = 0; i < 4; i++) step(1'b1, IN_W'(511), 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== SUM_W'(2044) || out_max !== IN_W'(511) || out_cnt !== CNT_W'(4)) begin
      failures++; $display("FAIL width_result got=%b %0d/%0d/%0d exp=1 2044/511/4", out_valid, out_sum, out_max, out_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) step(1'b1, IN_W'(i), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, IN_W'(9), 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, obs_ready); end
      checks++; if (out_valid !== 1'b1 || out_sum !== SUM_W'(10) || out_max !== IN_W'(4) || out_cnt !== CNT_W'(4)) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b %0d/%0d/%0d exp=1 10/4/4", c, out_valid, out_sum, out_max, out_cnt); end
    end
    step(1'b1, IN_W'(9), 1'b0, 1'b1);
    checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL bp_release got=ready %b valid %b exp=ready 1 valid 0", obs_ready, out_valid); end
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== SUM_W'(9) || out_max !== IN_W'(9) || out_cnt !== CNT_W'(1)) begin
      failures++; $display("FAIL bp_next_block got=%b %0d/%0d/%0d exp=1 9/9/1", out_valid, out_sum, out_max, out_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, IN_W'(i), 1'b0, 1'b1);
      checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL b2b_stall beat=%0d got=%b exp=1", i, obs_ready); end
      checks++; if (out_valid !== m_pending) begin failures++;
        $display("FAIL b2b_valid beat=%0d got=%b exp=%b", i, out_valid, m_pending); end
      if (i == 4 || i == 8) begin
        checks++; if (out_sum !== e_sum || out_max !== e_max || out_cnt !== e_cnt) begin failures++;
          $display("FAIL b2b_result beat=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, out_sum, out_max, out_cnt, e_sum, e_max, e_cnt); end
      end
    end
    checks++; if (out_sum !== SUM_W'(26) || out_max !== IN_W'(8) || out_cnt !== CNT_W'(4)) begin failures++;
      $display("FAIL b2b_second got=%0d/%0d/%0d exp=26/8/4", out_sum, out_max, out_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, IN_W'(5), 1'b0, 1'b1);
    step(1'b1, IN_W'(7), 1'b0, 1'b1);
    step(1'b1, IN_W'(3), 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== SUM_W'(15) || out_max !== IN_W'(7) || out_cnt !== CNT_W'(3)) begin
      failures++; $display("FAIL flush_partial got=%b %0d/%0d/%0d exp=1 15/7/3", out_valid, out_sum, out_max, out_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_late got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, IN_W'(2), 1'b0, 1'b1);
    step(1'b1, IN_W'(6), 1'b0, 1'b1);
    #2;
    arst_i = 1'b1;
    #1;
    blk.delete(); m_pending = 1'b0; e_sum = '0; e_max = '0; e_cnt = '0;
    checks++; if (out_valid !== 1'b0 || {out_sum, out_max, out_cnt} !== '0) begin failures++;
      $display("FAIL reset_async got=%b %0d/%0d/%0d exp=0 0/0/0", out_valid, out_sum, out_max, out_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_async_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    arst_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b1, IN_W'(1), 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== SUM_W'(4) || out_max !== IN_W'(1) || out_cnt !== CNT_W'(4)) begin
      failures++; $display("FAIL reset_clean got=%b %0d/%0d/%0d exp=1 4/1/4", out_valid, out_sum, out_max, out_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, IN_W'($urandom_range(0, 511)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      checks++; if (obs_ready !== m_ready) begin failures++;
        $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, obs_ready, m_ready); end
      checks++; if (out_valid !== m_pending) begin failures++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, m_pending); end
      if (m_pending) begin
        checks++; if (out_sum !== e_sum || out_max !== e_max || out_cnt !== e_cnt) begin failures++;
          $display("FAIL rand_result cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, out_sum, out_max, out_cnt, e_sum, e_max, e_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_block_accumulator.md
# sum_block_accumulator

Downstream consumer of the adder/FIFO top level: takes the stream of (DATA_IN_WIDTH+1)-bit sums over a valid/ready handshake, accumulates fixed-size blocks of BLOCK_LEN sums, and emits one result per block: block total, block maximum and beat count. An optional flush closes a partial block early. Registered output, one block result in flight, full-throughput back-to-back blocks.

## Interface

Parameters:
- DATA_IN_WIDTH, default 8. Operand width of the upstream adder. Input sum width IN_W = DATA_IN_WIDTH+1.
- BLOCK_LEN, default 4. Sums per block. Must be 2 or more.

Ports:
- clk_i, input, 1. Single clock; all state changes on its rising edge.
- arst_i, input, 1. Reset, asynchronous, active-high.
- in_sum, input, IN_W. Sum from the upstream output FIFO.
- in_valid, input, 1. in_sum is valid.
- in_ready, output, 1. Block accepts in_sum this cycle.
- flush_i, input, 1. Single-cycle request to close the current partial block.
- out_sum, output, SUM_W = IN_W + $clog2(BLOCK_LEN). Block total.
- out_max, output, IN_W. Largest sum in the block.
- out_cnt, output, CNT_W = $clog2(BLOCK_LEN+1). Number of sums in the block, 1..BLOCK_LEN.
- out_valid, output, 1. The result is valid.
- out_ready, input, 1. Downstream accepts the result.

## Operation

- Unsigned arithmetic throughout. SUM_W is wide enough for BLOCK_LEN × (2^IN_W − 1), so no overflow and no saturation.
- Internal state: acc (SUM_W), mx (IN_W), cnt (CNT_W), and a 2-state FSM {ACCUM, HOLD}.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = (state == ACCUM) | out_ready. This is combinational from out_ready; there is no path from in_valid to in_ready.
- ACCUM state:
  - On in_fire: acc += in_sum, mx = max(mx, in_sum), cnt += 1.
  - Block closes when the beat makes cnt == BLOCK_LEN.
  - Block also closes when flush_i = 1 and the post-beat count is ≥ 1. The same-cycle beat is included in the block.
  - On close: load out_sum/out_max/out_cnt with the post-beat values, clear acc/mx/cnt, go to HOLD.
  - flush_i with an empty block and no beat is ignored.
- HOLD state:
  - out_valid = 1. Output registers are frozen while out_ready = 0; in_ready = 0.
  - On out_fire with no in_fire: go to ACCUM.
  - On out_fire with a same-cycle in_fire: the beat is the first of the next block (acc = in_sum, mx = in_sum, cnt = 1). If BLOCK_LEN reached or flush_i is set, the new result loads directly and the state stays HOLD. Otherwise go to ACCUM.
  - flush_i in HOLD without in_fire is ignored.
- Reset (at any time, including mid-block or while HOLD):
  - State = ACCUM; acc, mx, cnt = 0.
  - out_valid = 0, out_sum = 0, out_max = 0, out_cnt = 0.
  - in_ready follows its equation, so it reads 1 during and after reset.
  - Any partial block is discarded.

## Timing

- Latency: out_valid rises on the clock edge that accepts the closing beat, i.e. the cycle after that beat is presented.
- Throughput: one sum per cycle sustained, including across block boundaries, provided out_ready is high when a result is pending.
- Downstream stall: in_ready = 0 for every cycle that out_valid = 1 and out_ready = 0. No input is lost or reordered.
- out_sum, out_max and out_cnt are driven only from registers. They are stable from the rise of out_valid until out_fire.
- out_valid drops on the edge after out_fire, unless a new block closes on that same edge.

## Test plan

- Basic block: reset; drive sums 10, 20, 30, 40 on consecutive cycles with out_ready = 1 → one result with out_sum = 100, out_max = 40, out_cnt = 4, out_valid high for exactly 1 cycle, on the cycle after 40 is accepted.
- Width boundary: four beats of 511 → out_sum = 2044 (11 bits, no wrap), out_max = 511, out_cnt = 4.
- Backpressure: complete the block 1, 2, 3, 4 with out_ready = 0 for 5 cycles while in_valid = 1 with value 9.
  - Required: in_ready = 0 throughout; outputs hold 10/4/4.
  - Then raise out_ready: the 9 is accepted on the out_fire cycle as the first beat of the next block (cnt = 1).
- Back-to-back blocks: stream 8 sums 1..8 continuously with out_ready = 1 → results (10, 4, 4) then (26, 8, 4) with no input stall cycles.
- Flush:
  - Beats 5, 7, then flush_i with a same-cycle beat 3 → out_sum = 15, out_max = 7, out_cnt = 3.
  - flush_i on an empty block → no output.
- Reset mid-operation:
  - Assert arst_i after 2 beats of a block → outputs all 0 immediately, without waiting for a clock edge.
  - Next 4 beats 1, 1, 1, 1 → out_sum = 4, out_cnt = 4; the pre-reset data does not appear.
